uart_word_tx: RTL and testbench

UART transmitter that serialises 32-bit words onto a single TX line, 8N1 format.
Each word is sent as four bytes, least-significant byte first, so a word is framed exactly as the instruction loader's receive path expects it.
Sits on the processor/GPIO side of the wrapper and returns status or loopback data to the host over the same serial link that the receiver uses for program upload.

---
 rtl/uart_word_tx.sv | 146 ++++++++++++++
 tb/tb_uart_word_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// UART 8N1 transmitter for 32-bit words, sent as four bytes with the LSB byte first.
// Idle mark cycles can optionally be inserted between the bytes of one word.
module uart_word_tx #(
    parameter int unsigned BIT_RATE = 9600,
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned GAP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_tx_en,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic        word_done
);

    localparam int unsigned CPB     = CLK_HZ / BIT_RATE;
    localparam int unsigned GAP_CYC = (GAP_BITS == 0) ? 1 : GAP_BITS * CPB;
    localparam int unsigned CNT_MAX = (GAP_CYC > CPB) ? GAP_CYC : CPB;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned WORD_W  = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic [1:0]          idx_q, idx_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic                txd_q, txd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bit_end;
    logic                gap_end;

    assign word_ready = (state_q == S_IDLE) && uart_tx_en && !rst;
    assign bit_end    = (cnt_q == CNT_W'(CPB - 1));
    assign gap_end    = (cnt_q == CNT_W'(GAP_CYC - 1));

    // State and datapath registers; reset parks the line at mark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state; shift_q[0] is always the bit currently on the line in DATA.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (word_valid && word_ready) begin
                    state_d = S_START;
                    shift_d = word_data;
                    idx_d   = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 2'd3) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = (GAP_BITS == 0) ? S_START : S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are precomputed from next-state values so they register in step with the state.
    always_comb begin
        txd_d  = 1'b1;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (cnt_d == CNT_W'(CPB - 1)) && (idx_d == 2'd3);
        unique case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    assign uart_txd  = txd_q;
    assign tx_busy   = busy_q;
    assign word_done = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: two instances (GAP_BITS=1 and 0, CPB=10) checked against a
// frame-level waveform model plus an independent mid-bit byte decoder.
module tb_uart_word_tx;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  en = 2'b11;
    logic [1:0]  valid = 2'b00;
    logic [31:0] data [2];
    logic        ready_g1, txd_g1, busy_g1, done_g1;
    logic        ready_g0, txd_g0, busy_g0, done_g0;
    logic [1:0]  ready, txd, busy, done;

    int vectors = 0;
    int fails = 0;

    assign ready = {ready_g1, ready_g0};
    assign txd   = {txd_g1, txd_g0};
    assign busy  = {busy_g1, busy_g0};
    assign done  = {done_g1, done_g0};

    always #5 clk = ~clk;

    uart_word_tx #(.BIT_RATE(9600), .CLK_HZ(96000), .GAP_BITS(1)) u_dut_g1 (
        .clk(clk), .rst(rst), .uart_tx_en(en[1]), .word_valid(valid[1]),
        .word_data(data[1]), .word_ready(ready_g1), .uart_txd(txd_g1),
        .tx_busy(busy_g1), .word_done(done_g1)
    );

    uart_word_tx #(.BIT_RATE(9600), .CLK_HZ(96000), .GAP_BITS(0)) u_dut_g0 (
        .clk(clk), .rst(rst), .uart_tx_en(en[0]), .word_valid(valid[0]),
        .word_data(data[0]), .word_ready(ready_g0), .uart_txd(txd_g0),
        .tx_busy(busy_g0), .word_done(done_g0)
    );

    function automatic int gap_of(input int s);
        return (s == 1) ? 1 : 0;
    endfunction

    // Offer a word and wait (bounded) for the accepting edge; data is scrambled afterwards.
    task automatic offer(input int s, input logic [31:0] w, input bit hold);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        valid[s] = 1'b1;
        data[s]  = w;
        for (int c = 0; c < 300; c++) begin
            if (ready[s] === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!ok) begin
            fails++;
            $display("FAIL accept_timeout inst=%0d word=%h got not-accepted want accepted", s, w);
        end
        #1;
        if (!hold) valid[s] = 1'b0;
        data[s] = $urandom;
    endtask

    // Model: expected line level per cycle from the frame bit list, then decode bytes.
    task automatic xmit_check(input int s, input logic [31:0] w, input int drop_at, input int rst_at);
        bit   frame[$];
        bit   rec[$];
        int   g;
        int   len;
        int   p;
        bit   aborted;
        logic exp_bit;
        logic exp_done;
        logic [7:0] got;
        g = gap_of(s);
        len = (40 + 3 * g) * CPB;
        aborted = 1'b0;
        for (int b = 0; b < 4; b++) begin
            frame.push_back(1'b0);
            for (int i = 0; i < 8; i++) frame.push_back(w[8*b+i]);
            frame.push_back(1'b1);
            if (b < 3) for (int k = 0; k < g; k++) frame.push_back(1'b1);
        end
        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            exp_bit  = frame[n / CPB];
            exp_done = (n == len - 1);
            vectors++;
            if (txd[s] !== exp_bit) begin
                fails++;
                $display("FAIL txd inst=%0d word=%h cycle=%0d got %b want %b", s, w, n, txd[s], exp_bit);
            end
            vectors++;
            if (busy[s] !== 1'b1) begin
                fails++;
                $display("FAIL tx_busy inst=%0d word=%h cycle=%0d got %b want 1", s, w, n, busy[s]);
            end
            vectors++;
            if (done[s] !== exp_done) begin
                fails++;
                $display("FAIL word_done inst=%0d word=%h cycle=%0d got %b want %b", s, w, n, done[s], exp_done);
            end
            rec.push_back(txd[s]);
            if (n == drop_at) begin
                en[s]    = 1'b0;
                valid[s] = 1'b1;
                data[s]  = $urandom;
            end
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                vectors++;
                if (txd[s] !== 1'b1 || busy[s] !== 1'b0 || done[s] !== 1'b0) begin
                    fails++;
                    $display("FAIL rst_mid inst=%0d got txd=%b busy=%b done=%b want 1 0 0",
                             s, txd[s], busy[s], done[s]);
                end
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            p = 0;
            for (int b = 0; b < 4; b++) begin
                while (p < rec.size() && rec[p] != 1'b0) p++;
                vectors++;
                if (p + 9 * CPB + CPB / 2 >= rec.size()) begin
                    fails++;
                    $display("FAIL decode_frame inst=%0d byte=%0d got no start bit want start bit", s, b);
                    break;
                end
                for (int i = 0; i < 8; i++) got[i] = rec[p + CPB * (1 + i) + CPB / 2];
                if (got !== w[8*b +: 8] || rec[p + 9 * CPB + CPB / 2] != 1'b1) begin
                    fails++;
                    $display("FAIL decode_byte inst=%0d byte=%0d got %h want %h (stop=%b)",
                             s, b, got, w[8*b +: 8], rec[p + 9 * CPB + CPB / 2]);
                end
                p += 10 * CPB;
            end
            @(negedge clk);
            vectors++;
            if (busy[s] !== 1'b0 || txd[s] !== 1'b1 || done[s] !== 1'b0) begin
                fails++;
                $display("FAIL idle_after inst=%0d got busy=%b txd=%b done=%b want 0 1 0",
                         s, busy[s], txd[s], done[s]);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (ready !== 2'b00 || txd !== 2'b11 || busy !== 2'b00 || done !== 2'b00) begin
            fails++;
            $display("FAIL reset_state got ready=%b txd=%b busy=%b done=%b want 00 11 00 00",
                     ready, txd, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (ready !== 2'b11) begin
            fails++;
            $display("FAIL ready_after_reset got %b want 11", ready);
        end
    endtask

    task automatic test_known_word();
        offer(1, 32'h1234_5678, 1'b0);
        xmit_check(1, 32'h1234_5678, -1, -1);
    endtask

    task automatic test_random_words();
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            w = $urandom;
            offer(1, w, 1'b0);
            xmit_check(1, w, -1, -1);
        end
        for (int k = 0; k < 2; k++) begin
            w = $urandom;
            offer(0, w, 1'b0);
            xmit_check(0, w, -1, -1);
        end
    endtask

    task automatic test_back_to_back();
        offer(0, 32'hFFFF_FFFF, 1'b1);
        data[0] = 32'h0000_0000;
        xmit_check(0, 32'hFFFF_FFFF, -1, -1);
        vectors++;
        if (ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready got %b want 1", ready[0]);
        end
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        xmit_check(0, 32'h0000_0000, -1, -1);
    endtask

    task automatic test_enable_gate();
        @(negedge clk);
        en[1]    = 1'b0;
        valid[1] = 1'b1;
        data[1]  = 32'h3C5A_0FF1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            vectors++;
            if (ready[1] !== 1'b0 || txd[1] !== 1'b1) begin
                fails++;
                $display("FAIL en_gate cycle=%0d got ready=%b txd=%b want 0 1", c, ready[1], txd[1]);
            end
        end
        en[1] = 1'b1;
        @(posedge clk);
        #1;
        valid[1] = 1'b0;
        xmit_check(1, 32'h3C5A_0FF1, -1, -1);
    endtask

    task automatic test_en_drop();
        offer(1, 32'hA5A5_A5A5, 1'b0);
        xmit_check(1, 32'hA5A5_A5A5, 2 * 11 * CPB + 15, -1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if (ready[1] !== 1'b0 || txd[1] !== 1'b1 || busy[1] !== 1'b0) begin
                fails++;
                $display("FAIL en_drop_hold cycle=%0d got ready=%b txd=%b busy=%b want 0 1 0",
                         c, ready[1], txd[1], busy[1]);
            end
        end
        valid[1] = 1'b0;
        en[1]    = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        offer(1, 32'h5A3C_96E1, 1'b0);
        xmit_check(1, 32'h5A3C_96E1, -1, 15 * CPB + 5);
        @(negedge clk);
        vectors++;
        if (txd[1] !== 1'b1 || done[1] !== 1'b0) begin
            fails++;
            $display("FAIL rst_hold got txd=%b done=%b want 1 0", txd[1], done[1]);
        end
        rst = 1'b0;
        w = $urandom;
        offer(1, w, 1'b0);
        xmit_check(1, w, -1, -1);
    endtask

    initial begin
        data[0] = '0;
        data[1] = '0;
        test_reset();
        test_known_word();
        test_random_words();
        test_back_to_back();
        test_enable_gate();
        test_en_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
